pc_unit: RTL
============

Name: pc_unit

Overview:
- Program-counter register and next-PC sequencer for the single-cycle MIPS datapath.
- Consumes the PC+4 and branch-target sums produced by the datapath adders, plus jump and register-jump targets.
- Registers the selected next PC each cycle and drives it to instruction memory and back into the PC+4 adder.
- Adds stall hold, a boot cycle after reset, misaligned-target fault trapping and a retired-instruction counter.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
TRAP_VECTOR, 32'h0000_0080, PC value loaded when a fault is acknowledged.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
Stall  input  1  hold PC and counter this cycle.
PCPlus4  input  32  sequential next address from the PC adder.
BranchTarget  input  32  branch target from the branch adder.
JumpTarget  input  32  J/JAL target, already formed.
RegTarget  input  32  JR target, taken from the register file.
Branch  input  1  beq-type branch decoded.
Zero  input  1  ALU zero flag.
Jump  input  1  J/JAL decoded.
JumpReg  input  1  JR decoded.
FaultAck  input  1  fault handler acknowledge.
PC  output  32  current program counter.
PCValid  output  1  PC addresses a valid fetch this cycle.
MisalignFault  output  1  fault pending.
FaultAddr  output  32  offending target address.
RetiredCount  output  32  number of PC advances since reset.

Behaviour:
- Single clock domain.
- Reset is asynchronous and active-low on rst_n; all state is cleared immediately on assertion, regardless of clk.
- Reset values:
  - PC = RESET_VECTOR.
  - PCValid = 0.
  - MisalignFault = 0.
  - FaultAddr = 0.
  - RetiredCount = 0.
  - State = BOOT.
- BOOT state:
  - PCValid = 0.
  - On the first rising edge after rst_n deasserts, go to RUN; PC is unchanged.
- RUN state:
  - PCValid = 1.
  - Next-PC priority: JumpReg, then Jump, then (Branch & Zero), then PCPlus4.
  - Branch with Zero = 0 selects PCPlus4.
- Stall = 1 in RUN:
  - PC, RetiredCount and state all hold.
  - No fault check is performed.
- Stall = 0 in RUN:
  - If selected_next[1:0] != 2'b00, enter FAULT. PC holds, FaultAddr <= selected_next, MisalignFault <= 1, and RetiredCount does not increment.
  - Otherwise PC <= selected_next and RetiredCount <= RetiredCount + 1. The counter wraps modulo 2^32 (32'hFFFF_FFFF + 1 = 0), with no flag.
- FAULT state:
  - PCValid = 0 and MisalignFault = 1.
  - Stall, Branch, Jump and JumpReg are ignored.
  - On FaultAck = 1: PC <= TRAP_VECTOR, MisalignFault <= 0, state goes to RUN, and RetiredCount is unchanged.
  - FaultAddr holds its value until the next fault.
- FaultAck is ignored outside FAULT.
- Latency: the next PC is visible one clock after the control inputs are sampled. PC is a purely registered output; there is no combinational path from the inputs to PC.
- Arithmetic: the block contains no adders except the RetiredCount increment. Targets are used as given.
- Reset mid-operation (any state, including FAULT): immediate return to the reset values. A pending fault is discarded.

Test Plan:
1. Reset, then release with PCPlus4 = PC+4 each cycle for 3 cycles -> PCValid 0 for the first cycle, then PC = 0x0, 0x4, 0x8, 0xC; RetiredCount = 3.
2. Branch=1, Zero=1, BranchTarget=0x40 -> PC = 0x40 next cycle. Repeat with Zero=0 -> PC = PCPlus4.
3. JumpReg=1, Jump=1, Branch=1, Zero=1 all asserted, with RegTarget=0x100, JumpTarget=0x200, BranchTarget=0x300 -> PC = 0x100.
4. Stall=1 for 2 cycles while Jump=1 and JumpTarget=0x200 -> PC and RetiredCount unchanged. Then Stall=0 -> PC = 0x200.
5. Jump=1 with JumpTarget=0x202 -> MisalignFault=1, FaultAddr=0x202, PC unchanged, PCValid=0. FaultAck=1 after 3 cycles -> PC=0x80, PCValid=1, MisalignFault=0.
6. Preload RetiredCount to 0xFFFF_FFFF (via force) and advance once -> 0. Then assert rst_n=0 asynchronously mid-cycle while in FAULT -> outputs return to reset values immediately.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter and next-PC sequencer for the single-cycle MIPS datapath.
// Includes stall hold, a boot cycle, misaligned-target trapping and a retired counter.
module pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic [31:0] PCPlus4,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] RegTarget,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        FaultAck,
    output logic [31:0] PC,
    output logic        PCValid,
    output logic        MisalignFault,
    output logic [31:0] FaultAddr,
    output logic [31:0] RetiredCount
);

    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic        fault_q, fault_d;
    logic [31:0] retired_q;
    logic        retire;
    logic [31:0] selected_next;

    always_comb begin
        selected_next = PCPlus4;
        if (JumpReg)
            selected_next = RegTarget;
        else if (Jump)
            selected_next = JumpTarget;
        else if (Branch && Zero)
            selected_next = BranchTarget;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        retire       = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (!Stall) begin
                    // Misaligned targets trap without moving the PC so the handler sees the source.
                    if (selected_next[1:0] != 2'b00) begin
                        state_d      = FAULT;
                        fault_d      = 1'b1;
                        fault_addr_d = selected_next;
                    end else begin
                        pc_d   = selected_next;
                        retire = 1'b1;
                    end
                end
            end
            FAULT: begin
                if (FaultAck) begin
                    state_d = RUN;
                    pc_d    = TRAP_VECTOR;
                    fault_d = 1'b0;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
            retired_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            if (retire)
                retired_q <= retired_q + 32'd1;
        end
    end

    assign PC            = pc_q;
    assign PCValid       = (state_q == RUN);
    assign MisalignFault = fault_q;
    assign FaultAddr     = fault_addr_q;
    assign RetiredCount  = retired_q;

endmodule
